// File: rtl/pl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Register fields are stored at REG_AW_MAX bits so one tag type serves any REG_AW up to that width.
package pl_pkg;

  localparam int REG_AW_MAX = 8;

  // Forward-select codes: 0 keeps the ID/EX register-file copy, k selects post-EX stage k.
  localparam int FWD_NONE = 0;
  localparam int FWD_MEM  = 1;
  localparam int FWD_WB   = 2;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] rd;
    logic                  regwrite;
    logic                  memread;
    logic [REG_AW_MAX-1:0] rs1;
    logic [REG_AW_MAX-1:0] rs2;
    logic                  rs1_used;
    logic                  rs2_used;
  } tag_t;

endpackage

// File: rtl/pl_hazard_fwd_match.sv
// Priority match of one EX source register against post-EX stages 1..FWD_DEPTH.
// The nearest matching producer wins; a load that has not yet delivered its data yields no forward.
module pl_fwd_match
  import pl_pkg::*;
#(
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
  input  logic                                  consumer_valid,
  input  logic [REG_AW_MAX-1:0]                 src,
  input  logic                                  src_used,
  input  logic [FWD_DEPTH:1]                    post_valid,
  input  logic [FWD_DEPTH:1]                    post_write,
  input  logic [FWD_DEPTH:1]                    post_load,
  input  logic [FWD_DEPTH:1][REG_AW_MAX-1:0]    post_rd,
  output logic [SEL_W-1:0]                      sel
);

  logic             hit_found;
  logic             hit_early_load;
  logic [SEL_W-1:0] hit_k;

  // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    hit_found      = 1'b0;
    hit_early_load = 1'b0;
    hit_k          = SEL_W'(FWD_NONE);
    // Scan far-to-near so the last hit written is the nearest stage.
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (post_valid[k] && post_write[k] && (post_rd[k] == src)) begin
        hit_found      = 1'b1;
        hit_early_load = post_load[k] && (k < LOAD_READY);
        hit_k          = SEL_W'(k);
      end
    end
  end

  always_comb begin
    sel = SEL_W'(FWD_NONE);
    if (consumer_valid && src_used && (src != '0) && hit_found && !hit_early_load) begin
      sel = hit_k;
    end
  end

`ifndef SYNTHESIS
  // The ID stall keeps a consumer out of EX until its load producer has reached LOAD_READY.
  always_comb begin
    if (consumer_valid && src_used && (src != '0)) begin
      assert (!(hit_found && hit_early_load));
    end
  end
`endif

endmodule

// File: rtl/pl_hazard_fwd.sv
// Hazard detection and EX operand forwarding for in-order RV32 pipelines of any post-EX depth.
// Optional PL_HAZARD_PERF_EN adds stall/forward/flush event counters.
module pl_hazard_fwd
  import pl_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b
`ifdef PL_HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_fwd_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  // Entry 0 is EX; entry k is the k-th stage after EX.
  tag_t tags_q [0:FWD_DEPTH];
  tag_t tags_d [0:FWD_DEPTH];
  tag_t id_tag;
  logic load_hazard;

  logic [FWD_DEPTH:1]                 post_valid;
  logic [FWD_DEPTH:1]                 post_write;
  logic [FWD_DEPTH:1]                 post_load;
  logic [FWD_DEPTH:1][REG_AW_MAX-1:0] post_rd;

  always_comb begin
    id_tag          = '0;
    id_tag.valid    = id_valid;
    id_tag.rd       = REG_AW_MAX'(id_rd);
    id_tag.regwrite = id_regwrite && (id_rd != '0);
    id_tag.memread  = id_memread;
    id_tag.rs1      = REG_AW_MAX'(id_rs1);
    id_tag.rs2      = REG_AW_MAX'(id_rs2);
    id_tag.rs1_used = id_rs1_used;
    id_tag.rs2_used = id_rs2_used;
  end

  // A load j stages past EX reaches distance j+1 by the time the ID consumer would enter EX.
  always_comb begin
    load_hazard = 1'b0;
    for (int j = 0; j <= FWD_DEPTH; j++) begin
      if ((j + 1 < LOAD_READY) && tags_q[j].valid && tags_q[j].regwrite && tags_q[j].memread) begin
        if (id_tag.rs1_used && (id_tag.rs1 != '0) && (tags_q[j].rd == id_tag.rs1)) load_hazard = 1'b1;
        if (id_tag.rs2_used && (id_tag.rs2 != '0) && (tags_q[j].rd == id_tag.rs2)) load_hazard = 1'b1;
      end
    end
    stall = id_valid && !flush && load_hazard;
  end

  always_comb begin
    tags_d[0] = (id_valid && !stall && !flush) ? id_tag : '0;
    for (int k = 1; k <= FWD_DEPTH; k++) tags_d[k] = tags_q[k-1];
  end

  // NOTE: the whole tag array is reset, not just the valid bits, so in-flight tags vanish cleanly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= FWD_DEPTH; k++) tags_q[k] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every entry shifts from the old value.
      for (int k = 0; k <= FWD_DEPTH; k++) tags_q[k] <= tags_d[k];
    end
  end

  always_comb begin
    for (int k = 1; k <= FWD_DEPTH; k++) begin
      post_valid[k] = tags_q[k].valid;
      post_write[k] = tags_q[k].regwrite;
      post_load[k]  = tags_q[k].memread;
      post_rd[k]    = tags_q[k].rd;
    end
  end

  pl_fwd_match #(.FWD_DEPTH(FWD_DEPTH), .LOAD_READY(LOAD_READY), .SEL_W(SEL_W)) u_match_a (
    .consumer_valid (tags_q[0].valid),
    .src            (tags_q[0].rs1),
    .src_used       (tags_q[0].rs1_used),
    .post_valid     (post_valid),
    .post_write     (post_write),
    .post_load      (post_load),
    .post_rd        (post_rd),
    .sel            (fwd_sel_a)
  );

  pl_fwd_match #(.FWD_DEPTH(FWD_DEPTH), .LOAD_READY(LOAD_READY), .SEL_W(SEL_W)) u_match_b (
    .consumer_valid (tags_q[0].valid),
    .src            (tags_q[0].rs2),
    .src_used       (tags_q[0].rs2_used),
    .post_valid     (post_valid),
    .post_write     (post_write),
    .post_load      (post_load),
    .post_rd        (post_rd),
    .sel            (fwd_sel_b)
  );

`ifdef PL_HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_fwd_q,   perf_fwd_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q + {31'b0, stall};
    perf_fwd_d   = perf_fwd_q + {31'b0, ((fwd_sel_a != '0) || (fwd_sel_b != '0))};
    perf_flush_d = perf_flush_q + {31'b0, flush};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_fwd_q   <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_fwd_q   <= perf_fwd_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_fwd_cnt   = perf_fwd_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pl_hazard_fwd.sv
// Bench for pl_hazard_fwd: a default instance and a LOAD_READY=3/FWD_DEPTH=3 instance run the same
// programs, each fetching on its own stall, checked every cycle against an instruction-history model.
module tb_pl_hazard_fwd;
  import pl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    bit valid;
    int rd, rs1, rs2;
    bit u1, u2, wr, ld;
  } instr_t;

  typedef struct {
    instr_t ins;
    bit     fl;
  } slot_t;

  logic       id_valid [2];
  logic [4:0] id_rs1 [2], id_rs2 [2], id_rd [2];
  logic       id_u1 [2], id_u2 [2], id_wr [2], id_ld [2];
  logic       flush [2];
  logic       stall_o [2];
  logic [1:0] sel_a_o [2], sel_b_o [2];
`ifdef PL_HAZARD_PERF_EN
  logic [31:0] pst [2], pfw [2], pfl [2];
`endif

  pl_hazard_fwd dut0 (
    .clk(clk), .reset(reset), .id_valid(id_valid[0]), .id_rs1(id_rs1[0]), .id_rs2(id_rs2[0]),
    .id_rs1_used(id_u1[0]), .id_rs2_used(id_u2[0]), .id_rd(id_rd[0]), .id_regwrite(id_wr[0]),
    .id_memread(id_ld[0]), .flush(flush[0]), .stall(stall_o[0]), .fwd_sel_a(sel_a_o[0]),
    .fwd_sel_b(sel_b_o[0])
`ifdef PL_HAZARD_PERF_EN
    , .perf_stall_cnt(pst[0]), .perf_fwd_cnt(pfw[0]), .perf_flush_cnt(pfl[0])
`endif
  );

  pl_hazard_fwd #(.LOAD_READY(3), .FWD_DEPTH(3)) dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid[1]), .id_rs1(id_rs1[1]), .id_rs2(id_rs2[1]),
    .id_rs1_used(id_u1[1]), .id_rs2_used(id_u2[1]), .id_rd(id_rd[1]), .id_regwrite(id_wr[1]),
    .id_memread(id_ld[1]), .flush(flush[1]), .stall(stall_o[1]), .fwd_sel_a(sel_a_o[1]),
    .fwd_sel_b(sel_b_o[1])
`ifdef PL_HAZARD_PERF_EN
    , .perf_stall_cnt(pst[1]), .perf_fwd_cnt(pfw[1]), .perf_flush_cnt(pfl[1])
`endif
  );

  int checks = 0;
  int failures = 0;

  // hist[c][k] is the instruction that entered EX k cycles ago in pipeline c (bubble if none).
  instr_t hist [2][4];
  int dep [2] = '{2, 3};
  int lr  [2] = '{2, 3};
  int unsigned exp_pst [2], exp_pfw [2], exp_pfl [2];
  logic [31:0] obs_st [2][64], obs_sa [2][64], obs_sb [2][64];
  slot_t prog [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic instr_t bubble();
    instr_t x = '{default: 0};
    return x;
  endfunction

  function automatic instr_t mk(int rd, int rs1, int rs2, bit u1, bit u2, bit wr, bit ld);
    instr_t x;
    x.valid = 1; x.rd = rd; x.rs1 = rs1; x.rs2 = rs2;
    x.u1 = u1; x.u2 = u2; x.wr = wr; x.ld = ld;
    return x;
  endfunction

  function automatic instr_t i_add(int rd, int rs1, int rs2); return mk(rd, rs1, rs2, 1, 1, 1, 0); endfunction
  function automatic instr_t i_addi(int rd, int rs1);         return mk(rd, rs1, 0, 1, 0, 1, 0);   endfunction
  function automatic instr_t i_lw(int rd, int rs1);           return mk(rd, rs1, 0, 1, 0, 1, 1);   endfunction
  function automatic instr_t i_nop();                         return mk(0, 0, 0, 1, 0, 1, 0);      endfunction

  function automatic slot_t sl(instr_t i, bit f);
    slot_t s;
    s.ins = i; s.fl = f;
    return s;
  endfunction

  // The consumer reaches EX one cycle after ID; a load j cycles into the pipe is then at distance j+1,
  // and its data exists only from distance LOAD_READY onward.
  function automatic bit waits_on_load(int c, int rs, bit used);
    if (!used || rs == 0) return 0;
    for (int j = 0; j <= dep[c]; j++) begin
      instr_t p = hist[c][j];
      if (p.valid && p.wr && p.ld && p.rd != 0 && p.rd == rs && j + 1 < lr[c]) return 1;
    end
    return 0;
  endfunction

  function automatic bit exp_stall(int c, slot_t s);
    return s.ins.valid && !s.fl && (waits_on_load(c, s.ins.rs1, s.ins.u1) || waits_on_load(c, s.ins.rs2, s.ins.u2));
  endfunction

  // Most recent earlier writer of the operand still in flight supplies it.
  function automatic int exp_sel(int c, bit opb);
    instr_t e = hist[c][0];
    int rs = opb ? e.rs2 : e.rs1;
    bit used = opb ? e.u2 : e.u1;
    if (!e.valid || !used || rs == 0) return FWD_NONE;
    for (int k = 1; k <= dep[c]; k++) begin
      instr_t p = hist[c][k];
      if (p.valid && p.wr && p.rd != 0 && p.rd == rs) return (p.ld && k < lr[c]) ? FWD_NONE : k;
    end
    return FWD_NONE;
  endfunction

  task automatic clear_model();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 4; k++) hist[c][k] = bubble();
      exp_pst[c] = 0; exp_pfw[c] = 0; exp_pfl[c] = 0;
    end
  endtask

  task automatic run(input string name, input int max_cycles, input bit expect_done);
    int    pc [2];
    slot_t s [2];
    bit    es [2];
    int    ea, eb;
    pc[0] = 0; pc[1] = 0;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      for (int c = 0; c < 2; c++) begin
        s[c] = (pc[c] < prog.size()) ? prog[pc[c]] : sl(bubble(), 1'b0);
        id_valid[c] = s[c].ins.valid;
        id_rd[c] = 5'(s[c].ins.rd); id_rs1[c] = 5'(s[c].ins.rs1); id_rs2[c] = 5'(s[c].ins.rs2);
        id_u1[c] = s[c].ins.u1; id_u2[c] = s[c].ins.u2;
        id_wr[c] = s[c].ins.wr; id_ld[c] = s[c].ins.ld;
        flush[c] = s[c].fl;
      end
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        es[c] = exp_stall(c, s[c]);
        ea = exp_sel(c, 1'b0);
        eb = exp_sel(c, 1'b1);
        check($sformatf("%s d%0d c%0d stall", name, c, cyc), 32'(stall_o[c]), 32'(es[c]));
        check($sformatf("%s d%0d c%0d sel_a", name, c, cyc), 32'(sel_a_o[c]), ea);
        check($sformatf("%s d%0d c%0d sel_b", name, c, cyc), 32'(sel_b_o[c]), eb);
        if (cyc < 64) begin
          obs_st[c][cyc] = 32'(stall_o[c]);
          obs_sa[c][cyc] = 32'(sel_a_o[c]);
          obs_sb[c][cyc] = 32'(sel_b_o[c]);
        end
        if (es[c]) exp_pst[c]++;
        if (ea != 0 || eb != 0) exp_pfw[c]++;
        if (s[c].fl) exp_pfl[c]++;
      end
      @(posedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
        for (int k = dep[c]; k >= 1; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = (s[c].ins.valid && !es[c] && !s[c].fl) ? s[c].ins : bubble();
        if (!es[c]) pc[c]++;
      end
    end
    if (expect_done) begin
      for (int c = 0; c < 2; c++) check($sformatf("%s d%0d program retired", name, c), 32'(pc[c] >= prog.size()), 1);
    end
  endtask

  task automatic check_perf(input string name);
`ifdef PL_HAZARD_PERF_EN
    for (int c = 0; c < 2; c++) begin
      check($sformatf("%s d%0d perf_stall", name, c), pst[c], exp_pst[c]);
      check($sformatf("%s d%0d perf_fwd", name, c), pfw[c], exp_pfw[c]);
      check($sformatf("%s d%0d perf_flush", name, c), pfl[c], exp_pfl[c]);
    end
`else
    checks = checks + 0 * name.len();
`endif
  endtask

  initial begin
    clear_model();
    for (int c = 0; c < 2; c++) begin
      id_valid[c] = 0; id_rs1[c] = 0; id_rs2[c] = 0; id_rd[c] = 0;
      id_u1[c] = 0; id_u2[c] = 0; id_wr[c] = 0; id_ld[c] = 0; flush[c] = 0;
    end

    // Reset state.
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      check($sformatf("reset d%0d stall", c), 32'(stall_o[c]), 0);
      check($sformatf("reset d%0d sel_a", c), 32'(sel_a_o[c]), FWD_NONE);
      check($sformatf("reset d%0d sel_b", c), 32'(sel_b_o[c]), FWD_NONE);
    end
    check_perf("reset");
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;

    // ALU back-to-back: MEM forward, no stall.
    prog.delete();
    prog.push_back(sl(i_add(7, 5, 6), 0));
    prog.push_back(sl(i_add(8, 7, 6), 0));
    run("t1", 10, 1);
    check("t1 stall c1", obs_st[0][1], 0);
    check("t1 sel_a c2", obs_sa[0][2], FWD_MEM);
    check("t1 sel_b c2", obs_sb[0][2], FWD_NONE);

    // One instruction apart: WB forward on operand B.
    prog.delete();
    prog.push_back(sl(i_add(7, 5, 6), 0));
    prog.push_back(sl(i_nop(), 0));
    prog.push_back(sl(i_add(9, 6, 7), 0));
    run("t2", 12, 1);
    check("t2 sel_b c3", obs_sb[0][3], FWD_WB);
    check("t2 sel_a c3", obs_sa[0][3], FWD_NONE);

    // Load-use: one stall on default, two on the deeper instance.
    prog.delete();
    prog.push_back(sl(i_lw(5, 0), 0));
    prog.push_back(sl(i_add(6, 5, 5), 0));
    run("t3", 12, 1);
    check("t3 d0 stall c1", obs_st[0][1], 1);
    check("t3 d0 stall c2", obs_st[0][2], 0);
    check("t3 d0 sel_a c3", obs_sa[0][3], FWD_WB);
    check("t3 d0 sel_b c3", obs_sb[0][3], FWD_WB);
    check("t3 d1 stall c1", obs_st[1][1], 1);
    check("t3 d1 stall c2", obs_st[1][2], 1);
    check("t3 d1 stall c3", obs_st[1][3], 0);
    check("t3 d1 sel_a c4", obs_sa[1][4], 3);

    // Nearest producer wins; x0 writers are invisible.
    prog.delete();
    prog.push_back(sl(i_lw(3, 0), 0));
    prog.push_back(sl(i_addi(3, 1), 0));
    prog.push_back(sl(i_add(4, 3, 0), 0));
    prog.push_back(sl(i_lw(0, 0), 0));
    prog.push_back(sl(i_add(1, 0, 0), 0));
    run("t4", 16, 1);
    check("t4 d0 sel_a c3", obs_sa[0][3], FWD_MEM);
    check("t4 d0 x0 stall c4", obs_st[0][4], 0);
    check("t4 d0 x0 sel_a c5", obs_sa[0][5], FWD_NONE);

    // Flush overrides a load-use stall and the squashed add never forwards.
    prog.delete();
    prog.push_back(sl(i_lw(5, 0), 0));
    prog.push_back(sl(i_add(6, 5, 5), 1));
    prog.push_back(sl(i_add(7, 6, 6), 0));
    run("t5", 12, 1);
    check("t5 d0 stall c1", obs_st[0][1], 0);
    check("t5 d0 sel_a c2", obs_sa[0][2], FWD_NONE);
    check("t5 d0 sel_a c3", obs_sa[0][3], FWD_NONE);
    check("t5 d1 stall c1", obs_st[1][1], 0);
    check_perf("directed");

    // Randomised program over a small register set to provoke frequent hazards.
    prog.delete();
    for (int i = 0; i < 300; i++) begin
      int t  = int'($urandom_range(0, 9));
      int rd = int'($urandom_range(0, 3));
      int r1 = int'($urandom_range(0, 3));
      int r2 = int'($urandom_range(0, 3));
      instr_t x;
      case (t)
        0, 1, 2: x = i_add(rd, r1, r2);
        3:       x = i_addi(rd, r1);
        4, 5, 6: x = i_lw(rd, r1);
        7:       x = i_nop();
        8:       begin x = i_add(rd, r1, r2); x.valid = 0; end
        default: x = mk(rd, r1, r2, 0, 1, 1, 0);
      endcase
      prog.push_back(sl(x, $urandom_range(0, 11) == 0));
    end
    run("rand", 300 * 3 + 8, 1);
    check_perf("rand");

    // Asynchronous reset with three valid tags in flight.
    prog.delete();
    prog.push_back(sl(i_add(1, 2, 3), 0));
    prog.push_back(sl(i_add(2, 1, 1), 0));
    prog.push_back(sl(i_add(3, 2, 2), 0));
    run("t6", 3, 0);
    check("t6 pre-reset sel_a", 32'(sel_a_o[0]), FWD_MEM);
    reset = 1'b1;
    #1;
    clear_model();
    for (int c = 0; c < 2; c++) begin
      check($sformatf("t6 d%0d stall", c), 32'(stall_o[c]), 0);
      check($sformatf("t6 d%0d sel_a", c), 32'(sel_a_o[c]), FWD_NONE);
      check($sformatf("t6 d%0d sel_b", c), 32'(sel_b_o[c]), FWD_NONE);
    end
    check_perf("t6");
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    prog.delete();
    prog.push_back(sl(i_lw(5, 0), 0));
    prog.push_back(sl(i_add(6, 5, 5), 0));
    run("t6b", 12, 1);
    check("t6b d1 sel_b c4", obs_sb[1][4], 3);
    check_perf("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pl_hazard_fwd.md
Name: pl_hazard_fwd

Overview:
- Parametrised hazard-detection and forwarding controller for the in-order RV32 pipelines.
- Successor to the fixed 5-stage load-use detector and two-source forwarding mux select.
- Keeps its own shift pipeline of destination tags, from EX through writeback. Generates the ID stall and per-operand EX forward selects for any post-EX depth.
- Adds flush handling, bubble tracking and configurable load-data latency.

Parameters:
- REG_AW, 5, register address width.
- FWD_DEPTH, 2, number of post-EX stages that can forward; stage 1 = MEM, stage FWD_DEPTH = writeback.
- LOAD_READY, 2, first post-EX stage index at which load data is valid. Legal range 1..FWD_DEPTH.
- SEL_W, $clog2(FWD_DEPTH+1), width of the forward-select buses.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction (not a bubble).
- id_rs1  in  REG_AW  ID source register 1.
- id_rs2  in  REG_AW  ID source register 2.
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2_used  in  1  instruction reads rs2.
- id_rd  in  REG_AW  ID destination register.
- id_regwrite  in  1  ID writes rd.
- id_memread  in  1  ID is a load.
- flush  in  1  branch/jump taken in EX; squash IF/ID and ID.
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX.
- fwd_sel_a  out  SEL_W  EX operand A source: 0 = ID/EX register-file copy, k = stage k result.
- fwd_sel_b  out  SEL_W  same for operand B.

Behaviour:
- Tag pipeline: entries 0..FWD_DEPTH. Entry 0 = EX, entry k = k-th stage after EX. Each entry holds {valid, rd, regwrite, memread, rs1, rs2, rs1_used, rs2_used}.
- Every cycle entry k <= entry k-1 for k >= 1. Post-EX stages never stall.
- Entry 0 loads the ID tag when id_valid & ~stall & ~flush; otherwise it loads a bubble (valid=0).
- A tag with rd==0 is treated as regwrite=0 when captured.
- Stall (combinational on ID inputs and registered tags) is 1 iff id_valid & ~flush and, for a used source rs != 0, some entry j satisfies all of:
  - valid, regwrite, memread;
  - rd == rs;
  - j+1 < LOAD_READY.
- Default LOAD_READY=2 gives exactly one stall cycle per load-use pair.
- Forwarding (combinational on entry 0 vs entries 1..FWD_DEPTH): for operand A, if entry-0 rs1_used and rs1 != 0, select the smallest k such that entry k is valid & regwrite & rd==rs1 and (~memread or k >= LOAD_READY).
  - Nearest stage wins. No match gives 0. Operand B is identical on rs2.
  - A match with memread & k < LOAD_READY cannot occur legally (the stall prevents it). Assertion-only; output is 0.
- Entry 0 invalid forces both selects to 0.
- flush and stall high together: flush wins, stall=0, entry 0 becomes a bubble.
- Register file is write-before-read, so no tracking beyond stage FWD_DEPTH.
- Reset (asynchronous): all entries invalid; stall=0, fwd_sel_a=0, fwd_sel_b=0 on the first cycle after reset. Reset mid-operation discards all in-flight tags immediately.
- Latency: stall is same-cycle (0). Forward selects are valid in the same cycle the consumer occupies EX.

Optional Feature:
- Macro PL_HAZARD_PERF_EN.
- Defined: adds outputs perf_stall_cnt[31:0], perf_fwd_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt increments on cycles with stall=1.
  - perf_fwd_cnt increments on cycles with either select nonzero.
  - perf_flush_cnt increments on flush=1.
  - Counters reset asynchronously to 0 and wrap at 2^32.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package pl_pkg: tag struct typedef (valid, rd, regwrite, memread, rs1/rs2, used bits) and localparam FWD_NONE = 0.
- Forwarding select constants replace the legacy forwarding_none/typeA/typeB defines. FWD_MEM = 1, FWD_WB = 2 hold for default depth.
- One sub-module, pl_fwd_match: priority match of one source register against entries 1..FWD_DEPTH. Instantiated twice (A, B).

Test Plan:
1. add x7,x5,x6 ; add x8,x7,x6 back-to-back (defaults) -> stall never 1; fwd_sel_a=1 while second add in EX.
2. add x7 ; nop ; sub x9,x6,x7 -> fwd_sel_b=2 in sub's EX cycle; fwd_sel_a=0.
3. lw x5,0(x0) ; add x6,x5,x5 -> stall=1 for exactly one cycle with add in ID; next cycle add in EX with fwd_sel_a=fwd_sel_b=2.
4. Same rd in MEM (addi x3) and WB (lw x3) -> fwd_sel_a=1 (nearest). Writes to x0 never cause stall or a nonzero select.
5. Load-use stall condition plus flush=1 same cycle -> stall=0; next-cycle EX entry is a bubble; selects=0.
6. Reset asserted mid-stream with three valid tags -> outputs 0 immediately. With PL_HAZARD_PERF_EN, counters=0. Rerun test 3 with LOAD_READY=3, FWD_DEPTH=3 -> two stall cycles, then fwd_sel=3.
